// File: rtl/bnb_pkg.sv
// Shared defaults and data type for the bnb_delay_pair delay cell.
package bnb_pkg;

    localparam int unsigned BNB_WIDTH_DEF = 1;
    localparam int unsigned BNB_DEPTH_DEF = 2;

    typedef logic [BNB_WIDTH_DEF-1:0] bnb_data_t;

endpackage

// File: rtl/bnb_stage.sv
// One WIDTH-bit D register with asynchronous active-low clear.
module bnb_stage #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bnb_delay_pair.sv
// One-cycle delay (path A) beside a DEPTH-stage shift register (path B).
// Define BNB_MISMATCH_EN to add a registered q_blk != q_nblk flag.
module bnb_delay_pair
    import bnb_pkg::*;
#(
    parameter int unsigned WIDTH = BNB_WIDTH_DEF,
    parameter int unsigned DEPTH = BNB_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_blk,
`ifdef BNB_MISMATCH_EN
    output logic             mismatch,
`endif
    output logic [WIDTH-1:0] q_nblk
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    bnb_stage #(.WIDTH(WIDTH)) u_path_a (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .q     (q_blk)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_path_b
        if (i == 0) begin : g_head
            bnb_stage #(.WIDTH(WIDTH)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (d),
                .q     (stage_q[0])
            );
        end else begin : g_tail
            bnb_stage #(.WIDTH(WIDTH)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (stage_q[i-1]),
                .q     (stage_q[i])
            );
        end
    end

    assign q_nblk = stage_q[DEPTH-1];

`ifdef BNB_MISMATCH_EN
    logic mismatch_d;

    // Compare the values both paths will present after this edge, so the
    // registered flag lines up with the outputs it describes.
    if (DEPTH > 1) begin : g_mm_cmp
        localparam int unsigned CmpIdx = DEPTH - 2;
        assign mismatch_d = (d != stage_q[CmpIdx]);
    end else begin : g_mm_zero
        assign mismatch_d = 1'b0;
    end

    bnb_stage #(.WIDTH(1)) u_mismatch (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mismatch_d),
        .q     (mismatch)
    );
`endif

endmodule

// File: tb/tb_bnb_delay_pair.sv
// Bench for bnb_delay_pair: three configurations against a history-queue model.
module tb_bnb_delay_pair;

    logic       clk;
    logic       rst_n;
    logic [0:0] d_a;
    logic [7:0] d_b;
    logic [3:0] d_c;
    logic [0:0] blk_a, nblk_a;
    logic [7:0] blk_b, nblk_b;
    logic [3:0] blk_c, nblk_c;
    logic       mm_a, mm_b, mm_c;

    int errors = 0;
    int checks = 0;

    // Histories of d sampled on each post-reset edge, newest first.
    logic [0:0] ha[$];
    logic [7:0] hb[$];
    logic [3:0] hc[$];

    bnb_delay_pair #(.WIDTH(1), .DEPTH(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .d(d_a), .q_blk(blk_a),
`ifdef BNB_MISMATCH_EN
        .mismatch(mm_a),
`endif
        .q_nblk(nblk_a)
    );

    bnb_delay_pair #(.WIDTH(8), .DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .d(d_b), .q_blk(blk_b),
`ifdef BNB_MISMATCH_EN
        .mismatch(mm_b),
`endif
        .q_nblk(nblk_b)
    );

    bnb_delay_pair #(.WIDTH(4), .DEPTH(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .d(d_c), .q_blk(blk_c),
`ifdef BNB_MISMATCH_EN
        .mismatch(mm_c),
`endif
        .q_nblk(nblk_c)
    );

`ifndef BNB_MISMATCH_EN
    assign mm_a = 1'b0;
    assign mm_b = 1'b0;
    assign mm_c = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #100 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ha.delete();
            hb.delete();
            hc.delete();
        end else begin
            ha.push_front(d_a);
            hb.push_front(d_b);
            hc.push_front(d_c);
            if (ha.size() > 8) void'(ha.pop_back());
            if (hb.size() > 8) void'(hb.pop_back());
            if (hc.size() > 8) void'(hc.pop_back());
        end
    end

    function automatic logic [7:0] past_b(input int n);
        return (hb.size() >= n) ? hb[n-1] : 8'h00;
    endfunction

    task automatic check_model();
        logic [0:0] ea_blk, ea_nblk;
        logic [7:0] eb_blk, eb_nblk;
        logic [3:0] ec_blk;
        ea_blk  = (ha.size() >= 1) ? ha[0] : 1'b0;
        ea_nblk = (ha.size() >= 2) ? ha[1] : 1'b0;
        eb_blk  = past_b(1);
        eb_nblk = past_b(4);
        ec_blk  = (hc.size() >= 1) ? hc[0] : 4'h0;
        check("model_a_blk",  32'(blk_a),  32'(ea_blk));
        check("model_a_nblk", 32'(nblk_a), 32'(ea_nblk));
        check("model_b_blk",  32'(blk_b),  32'(eb_blk));
        check("model_b_nblk", 32'(nblk_b), 32'(eb_nblk));
        check("model_c_blk",  32'(blk_c),  32'(ec_blk));
        check("model_c_nblk", 32'(nblk_c), 32'(ec_blk));
`ifdef BNB_MISMATCH_EN
        check("model_a_mm", 32'(mm_a), 32'(ea_blk != ea_nblk));
        check("model_b_mm", 32'(mm_b), 32'(eb_blk != eb_nblk));
        check("model_c_mm", 32'(mm_c), 32'h0);
`endif
    endtask

    // Per-cycle compare, mid high phase, well away from both edges.
    always @(posedge clk) begin
        #50;
        check_model();
    end

    initial begin
        logic [0:0] seq_d   [8];
        logic [0:0] seq_blk [8];
        logic [0:0] seq_nblk[8];
        logic [0:0] seq_mm  [8];
        seq_d    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        seq_blk  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        seq_nblk = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        seq_mm   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        d_a = 1'b1;
        d_b = 8'hFF;
        d_c = 4'hF;
        repeat (3) @(posedge clk);
        #50;
        check("rst_a_blk",  32'(blk_a),  32'h0);
        check("rst_a_nblk", 32'(nblk_a), 32'h0);
        check("rst_b_nblk", 32'(nblk_b), 32'h0);
        check("rst_c_blk",  32'(blk_c),  32'h0);
        check("rst_mm",     32'(mm_a),   32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k != 0) @(negedge clk);
            d_a = seq_d[k];
            d_b = (k == 2) ? 8'hA5 : 8'h00;
            d_c = 4'(k);
            @(posedge clk);
            #50;
            check("seq_blk",  32'(blk_a),  32'(seq_blk[k]));
            check("seq_nblk", 32'(nblk_a), 32'(seq_nblk[k]));
            check("w8_blk",   32'(blk_b),  (k == 2) ? 32'hA5 : 32'h0);
            check("w8_nblk",  32'(nblk_b), (k == 5) ? 32'hA5 : 32'h0);
`ifdef BNB_MISMATCH_EN
            check("seq_mm",   32'(mm_a),   32'(seq_mm[k]));
`endif
        end

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            d_a = 1'b1;
            d_b = 8'h3C;
            d_c = 4'h9;
        end
        @(posedge clk);
        #60;
        check("pre_rst_nblk", 32'(nblk_a), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_blk",    32'(blk_a),  32'h0);
        check("mid_rst_nblk",   32'(nblk_a), 32'h0);
        check("mid_rst_b_nblk", 32'(nblk_b), 32'h0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #50;
        check("rel1_blk",  32'(blk_a),  32'h1);
        check("rel1_nblk", 32'(nblk_a), 32'h0);
        check("rel1_c",    32'(nblk_c), 32'h9);
        @(posedge clk);
        #50;
        check("rel2_nblk", 32'(nblk_a), 32'h1);
        check("rel2_b",    32'(nblk_b), 32'h0);

        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            d_a = 1'($urandom_range(1, 0));
            d_b = 8'($urandom);
            d_c = 4'($urandom);
            @(posedge clk);
            #50;
            check("d1_equal", 32'(nblk_c), 32'(blk_c));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
